// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: OV7670-style parallel pixel bus transmitter (RGB444, two
// bytes per pixel) producing selectable test patterns with scaled VGA timing.
//
// Ports
//   clk          system clock
//   reset_       asynchronous active-low reset
//   enable       start a frame at the next frame boundary while high
//   pattern_sel  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
//   solid_color  {R,G,B} used by the solid pattern
//   pclk         pixel clock, clk/2
//   vsync        frame sync, active high
//   href         high during active bytes of active lines
//   d            pixel byte: even slot {0,R}, odd slot {G,B}
//   frame_done   one-clk pulse on the edge that ends a frame
module dvp_pattern_tx #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_BLANK       = 144,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned VSYNC_LINES   = 3,
    parameter int unsigned V_BACK_LINES  = 17,
    parameter int unsigned V_FRONT_LINES = 10
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done
);

    localparam int unsigned LINE_SLOTS  = 2 * (H_ACTIVE + H_BLANK);
    localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES;
    localparam int unsigned SLOT_W      = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
    localparam int unsigned LINE_W      = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int unsigned ACT_FIRST   = VSYNC_LINES + V_BACK_LINES;
    localparam int unsigned ACT_END     = ACT_FIRST + V_ACTIVE;
    localparam int unsigned ACT_SLOTS   = 2 * H_ACTIVE;
    localparam int unsigned BAR_W       = H_ACTIVE / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]        state,     state_nxt;
    logic [SLOT_W-1:0] slot_x,    slot_nxt;
    logic [LINE_W-1:0] line_y,    line_nxt;
    logic [1:0]        pat_sel,   pat_sel_nxt;
    logic [11:0]       pat_solid, pat_solid_nxt;
    logic              done_nxt;
    logic              vsync_nxt;
    logic              href_nxt;
    logic [7:0]        d_nxt;

    logic [15:0]       px;
    logic [2:0]        bar_idx;
    logic              py_b3;
    logic [11:0]       rgb;

    // Frame sequencing: everything advances only on the pclk 1->0 edge.
    always_comb begin
        state_nxt     = state;
        slot_nxt      = slot_x;
        line_nxt      = line_y;
        pat_sel_nxt   = pat_sel;
        pat_solid_nxt = pat_solid;
        done_nxt      = 1'b0;
        if (pclk) begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt     = ST_FRAME;
                        slot_nxt      = '0;
                        line_nxt      = '0;
                        pat_sel_nxt   = pattern_sel;
                        pat_solid_nxt = solid_color;
                    end
                end
                ST_FRAME: begin
                    if (slot_x == SLOT_W'(LINE_SLOTS - 1)) begin
                        slot_nxt = '0;
                        if (line_y == LINE_W'(FRAME_LINES - 1)) begin
                            line_nxt = '0;
                            done_nxt = 1'b1;
                            if (enable) begin
                                pat_sel_nxt   = pattern_sel;
                                pat_solid_nxt = solid_color;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            line_nxt = line_y + LINE_W'(1);
                        end
                    end else begin
                        slot_nxt = slot_x + SLOT_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Bus outputs for the slot about to be presented.
    always_comb begin
        vsync_nxt = (state_nxt == ST_FRAME) && (32'(line_nxt) < VSYNC_LINES);
        href_nxt  = (state_nxt == ST_FRAME)
                  && (32'(line_nxt) >= ACT_FIRST) && (32'(line_nxt) < ACT_END)
                  && (32'(slot_nxt) < ACT_SLOTS);

        px      = 16'(slot_nxt >> 1);
        bar_idx = 3'(px / 16'(BAR_W));
        // Only bit 3 of the active line index matters for the checkerboard.
        py_b3   = 1'((line_nxt - LINE_W'(ACT_FIRST)) >> 3);

        case (pat_sel_nxt)
            2'd0:    rgb = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
            2'd1:    rgb = {px[5:2], px[5:2], px[5:2]};
            2'd2:    rgb = (px[3] ^ py_b3) ? 12'hFFF : 12'h000;
            default: rgb = pat_solid_nxt;
        endcase

        d_nxt = 8'h00;
        if (href_nxt) begin
            d_nxt = slot_nxt[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
        end
    end

    // State, counters, latched pattern and registered bus outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= ST_IDLE;
            slot_x     <= '0;
            line_y     <= '0;
            pat_sel    <= 2'd0;
            pat_solid  <= 12'h000;
            pclk       <= 1'b0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot_x     <= slot_nxt;
            line_y     <= line_nxt;
            pat_sel    <= pat_sel_nxt;
            pat_solid  <= pat_solid_nxt;
            pclk       <= ~pclk;
            vsync      <= vsync_nxt;
            href       <= href_nxt;
            d          <= d_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: randomized self-checking bench for dvp_pattern_tx,
// compared clk by clk against a frame-slot based reference model.
module tb_dvp_pattern_tx;

    localparam int unsigned H_ACTIVE      = 16;
    localparam int unsigned H_BLANK       = 4;
    localparam int unsigned V_ACTIVE      = 4;
    localparam int unsigned VSYNC_LINES   = 1;
    localparam int unsigned V_BACK_LINES  = 1;
    localparam int unsigned V_FRONT_LINES = 1;

    localparam int LINE_SLOTS  = 2 * (H_ACTIVE + H_BLANK);
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES;
    localparam int FRAME_SLOTS = LINE_SLOTS * FRAME_LINES;
    localparam int ACT_FIRST   = VSYNC_LINES + V_BACK_LINES;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] solid_color = 12'h000;
    logic        pclk, vsync, href, frame_done;
    logic [7:0]  d;

    int checks = 0;
    int errors = 0;

    dvp_pattern_tx #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK_LINES(V_BACK_LINES),
        .V_FRONT_LINES(V_FRONT_LINES)
    ) dut (
        .clk(clk), .reset_(reset_), .enable(enable), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .pclk(pclk), .vsync(vsync), .href(href),
        .d(d), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a single slot index into the frame plus the latched pattern.
    logic        m_pclk, m_active, m_done;
    int          m_t;
    logic [1:0]  m_sel;
    logic [11:0] m_solid;

    function automatic logic [11:0] bar_color(input int idx);
        case (idx)
            0: return 12'hFFF;  1: return 12'hFF0;
            2: return 12'h0FF;  3: return 12'h0F0;
            4: return 12'hF0F;  5: return 12'hF00;
            6: return 12'h00F;  default: return 12'h000;
        endcase
    endfunction

    function automatic bit act_slot(input logic act, input int t);
        int line, slot;
        line = t / LINE_SLOTS;
        slot = t % LINE_SLOTS;
        return act && line >= ACT_FIRST && line < ACT_FIRST + V_ACTIVE && slot < 2 * H_ACTIVE;
    endfunction

    function automatic logic [7:0] exp_byte(input logic act, input int t,
                                            input logic [1:0] sel, input logic [11:0] solid);
        int slot, x, y, v;
        logic [11:0] c;
        if (!act_slot(act, t)) return 8'h00;
        slot = t % LINE_SLOTS;
        x = slot / 2;
        y = t / LINE_SLOTS - ACT_FIRST;
        case (sel)
            2'd0: c = bar_color(x / (H_ACTIVE / 8));
            2'd1: begin v = (x / 4) % 16; c = 12'(v * 12'h111); end
            2'd2: c = ((((x / 8) ^ (y / 8)) % 2) == 1) ? 12'hFFF : 12'h000;
            default: c = solid;
        endcase
        return (slot % 2 == 0) ? {4'h0, c[11:8]} : c[7:0];
    endfunction

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_pclk = 1'b0; m_active = 1'b0; m_done = 1'b0;
            m_t = 0; m_sel = 2'd0; m_solid = 12'h000;
        end else begin
            m_done = 1'b0;
            if (m_pclk) begin
                if (m_active) begin
                    m_t++;
                    if (m_t == FRAME_SLOTS) begin
                        m_done = 1'b1;
                        m_t = 0;
                        if (enable) begin m_sel = pattern_sel; m_solid = solid_color; end
                        else m_active = 1'b0;
                    end
                end else if (enable) begin
                    m_active = 1'b1; m_t = 0;
                    m_sel = pattern_sel; m_solid = solid_color;
                end
            end
            m_pclk = ~m_pclk;
        end
    end

    // Cycle-by-cycle comparison plus a direct vsync-width measurement.
    int vs_cnt = 0;
    always @(negedge clk) begin
        check("pclk", 32'(pclk), 32'(m_pclk));
        check("vsync", 32'(vsync), 32'(m_active && (m_t / LINE_SLOTS) < VSYNC_LINES));
        check("href", 32'(href), 32'(act_slot(m_active, m_t)));
        check("d", 32'(d), 32'(exp_byte(m_active, m_t, m_sel, m_solid)));
        check("frame_done", 32'(frame_done), 32'(m_done));
        if (!reset_) vs_cnt = 0;
        else if (vsync) vs_cnt++;
        else if (vs_cnt != 0) begin
            check("vsync_width", 32'(vs_cnt), 32'(2 * VSYNC_LINES * LINE_SLOTS));
            vs_cnt = 0;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int budget;
        // Reset and idle with enable low.
        run(4);
        reset_ = 1'b1;
        run(1000);

        // Each pattern for one full frame, with pattern_sel jittered mid-frame.
        for (int p = 0; p < 4; p++) begin
            pattern_sel = 2'(p);
            solid_color = (p == 3) ? 12'hA5C : 12'($urandom);
            enable = 1'b1;
            run(3);
            pattern_sel = 2'($urandom);
            solid_color = 12'($urandom);
            run(2 * FRAME_SLOTS - 200);
            enable = 1'b0;
            run(400);
        end

        // Random enable, pattern and colour activity.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) pattern_sel = 2'($urandom);
            if ($urandom_range(0, 49) == 0) solid_color = 12'($urandom);
        end
        enable = 1'b0;
        run(2 * FRAME_SLOTS + 10);

        // Drop enable and switch to solid during line 3: frame completes as bars.
        pattern_sel = 2'd0;
        enable = 1'b1;
        run(2 * 3 * LINE_SLOTS + 20);
        enable = 1'b0;
        pattern_sel = 2'd3;
        run(3 * FRAME_SLOTS);

        // Reset asserted during an active line.
        pattern_sel = 2'd1;
        enable = 1'b1;
        budget = 0;
        while (!href && budget < 4 * FRAME_SLOTS) begin
            @(negedge clk);
            budget++;
        end
        check("href_wait", 32'(href), 32'd1);
        #2 reset_ = 1'b0;
        #1;
        check("rst_pclk", 32'(pclk), 32'd0);
        check("rst_href", 32'(href), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        run(3);
        reset_ = 1'b1;
        run(2 * FRAME_SLOTS + 100);
        enable = 1'b0;
        run(2 * FRAME_SLOTS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
